// File: rtl/fiapp_fault_observer.sv
// fiapp_fault_observer
// ------------------------------------------------------------------
// Watches the three-flop enable/shift fault-injection app from the
// outside and flags cycles where its outputs disagree with what a
// fault-free block would produce.  Every faulty cycle is counted
// (saturating), the first one since reset/clear is snapshotted, and
// each one is queued as a {timestamp, type} event for a consumer.
//
// Check vector (type) bits:
//   [0] complement : o3 must be the inverse of o2
//   [1] shift      : o2 must equal o1 from the previous cycle
//   [2] golden     : o1 must equal the shadow copy of q1
//
// Ports:
//   clk, reset_n      clock, synchronous active-low reset
//   a, enable         stimulus seen by the observed block
//   o1, o2, o3        observed block outputs
//   clear             pulse: clears flags, count and first-fault snapshot
//   fault_flags       sticky OR of all check vectors
//   fault_count       saturating number of faulty cycles
//   first_ts/type     timestamp and check vector of the first fault
//   evt_valid/data    event FIFO head, {ts, type}
//   evt_ready         consumer pops head when evt_valid & evt_ready
//   evt_overflow      sticky: an event was dropped on a full FIFO
// ------------------------------------------------------------------
module fiapp_fault_observer #(
  parameter int CNT_W = 16,
  parameter int TS_W  = 24,
  parameter int DEPTH = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               a,
  input  logic               enable,
  input  logic               o1,
  input  logic               o2,
  input  logic               o3,
  input  logic               clear,
  output logic [2:0]         fault_flags,
  output logic [CNT_W-1:0]   fault_count,
  output logic [TS_W-1:0]    first_ts,
  output logic [2:0]         first_type,
  output logic               evt_valid,
  output logic [TS_W+2:0]    evt_data,
  input  logic               evt_ready,
  output logic               evt_overflow
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] FILL_ZERO = {(PTR_W+1){1'b0}};
  localparam logic [PTR_W:0] FILL_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0] FILL_FULL = (PTR_W+1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_WARMUP  = 2'd0,
    ST_MONITOR = 2'd1,
    ST_LATCHED = 2'd2
  } state_t;

  state_t              state_r;
  logic [TS_W-1:0]     ts_r;
  logic                shadow_q1_r;
  logic                prev_o1_r;

  logic [TS_W+2:0]     mem_r [DEPTH];
  logic [PTR_W-1:0]    rd_ptr_r;
  logic [PTR_W-1:0]    wr_ptr_r;
  logic [PTR_W:0]      fill_r;

  logic                check_en_s;
  logic [2:0]          type_s;
  logic                fault_s;
  logic                pop_s;
  logic                full_s;
  logic                accept_s;
  logic                drop_s;
  logic [PTR_W:0]      fill_next_s;
  logic [TS_W+2:0]     push_data_s;
  logic [TS_W+2:0]     head_next_s;

  // Per-cycle check vector; history-based checks are meaningless during warm-up.
  always_comb begin
    check_en_s = (state_r == ST_MONITOR) || (state_r == ST_LATCHED);
    if (check_en_s) begin
      type_s = {(o1 != shadow_q1_r), (o2 != prev_o1_r), (o3 == o2)};
    end else begin
      type_s = 3'b000;
    end
    fault_s     = |type_s;
    push_data_s = {ts_r, type_s};
  end

  // FIFO bookkeeping: a full FIFO still accepts a push when the head leaves the same cycle.
  always_comb begin
    pop_s    = (fill_r != FILL_ZERO) && evt_ready;
    full_s   = (fill_r == FILL_FULL);
    accept_s = fault_s && (!full_s || pop_s);
    drop_s   = fault_s && full_s && !pop_s;
    case ({accept_s, pop_s})
      2'b10:   fill_next_s = fill_r + FILL_ONE;
      2'b01:   fill_next_s = fill_r - FILL_ONE;
      default: fill_next_s = fill_r;
    endcase
    // Next head: the entry behind the current head, or the incoming event if the FIFO drains to it.
    if (pop_s) begin
      if (fill_r > FILL_ONE) begin
        head_next_s = mem_r[rd_ptr_r + PTR_W'(1)];
      end else if (accept_s) begin
        head_next_s = push_data_s;
      end else begin
        head_next_s = evt_data;
      end
    end else if ((fill_r == FILL_ZERO) && accept_s) begin
      head_next_s = push_data_s;
    end else begin
      head_next_s = evt_data;
    end
  end

  // Free-running timestamp and the golden shadow of the observed block's history.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ts_r        <= {TS_W{1'b0}};
      shadow_q1_r <= 1'b0;
      prev_o1_r   <= 1'b0;
    end else begin
      ts_r        <= ts_r + TS_W'(1);
      shadow_q1_r <= enable ? a : shadow_q1_r;
      prev_o1_r   <= o1;
    end
  end

  // Monitoring FSM with the sticky flags, saturating count and first-fault snapshot.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r     <= ST_WARMUP;
      fault_flags <= 3'b000;
      fault_count <= {CNT_W{1'b0}};
      first_ts    <= {TS_W{1'b0}};
      first_type  <= 3'b000;
    end else begin
      case (state_r)
        ST_WARMUP:  state_r <= ST_MONITOR;
        ST_MONITOR: state_r <= (!clear && fault_s) ? ST_LATCHED : ST_MONITOR;
        ST_LATCHED: state_r <= clear ? ST_MONITOR : ST_LATCHED;
        default:    state_r <= ST_WARMUP;
      endcase
      // clear wins over a same-cycle fault; that fault only reaches the FIFO.
      if (clear) begin
        fault_flags <= 3'b000;
        fault_count <= {CNT_W{1'b0}};
        first_ts    <= {TS_W{1'b0}};
        first_type  <= 3'b000;
      end else if (fault_s) begin
        fault_flags <= fault_flags | type_s;
        if (fault_count != {CNT_W{1'b1}}) begin
          fault_count <= fault_count + CNT_W'(1);
        end
        if (state_r == ST_MONITOR) begin
          first_ts   <= ts_r;
          first_type <= type_s;
        end
      end
    end
  end

  // Event FIFO storage, pointers and registered head/valid/overflow; untouched by clear.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {(TS_W+3){1'b0}};
      end
      rd_ptr_r     <= {PTR_W{1'b0}};
      wr_ptr_r     <= {PTR_W{1'b0}};
      fill_r       <= FILL_ZERO;
      evt_valid    <= 1'b0;
      evt_data     <= {(TS_W+3){1'b0}};
      evt_overflow <= 1'b0;
    end else begin
      if (accept_s) begin
        mem_r[wr_ptr_r] <= push_data_s;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      fill_r    <= fill_next_s;
      evt_valid <= (fill_next_s != FILL_ZERO);
      evt_data  <= head_next_s;
      if (drop_s) begin
        evt_overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fiapp_fault_observer.sv
// Directed bench for fiapp_fault_observer.  A correct fiapp model drives
// the observed outputs; force knobs corrupt them.  A queue-based model of
// the observer's rules is compared against the DUT every cycle, and a
// second instance with CNT_W=4 covers counter saturation.
module tb_fiapp_fault_observer;

  localparam int CNT_W = 16;
  localparam int TS_W  = 24;
  localparam int DEPTH = 8;
  localparam int EW    = TS_W + 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n, a, enable, o1, o2, o3, clear, evt_ready;

  logic [2:0]       fault_flags, first_type;
  logic [CNT_W-1:0] fault_count;
  logic [TS_W-1:0]  first_ts;
  logic             evt_valid, evt_overflow;
  logic [EW-1:0]    evt_data;

  logic [2:0]       d4_flags, d4_first_type;
  logic [3:0]       d4_count;
  logic [TS_W-1:0]  d4_first_ts;
  logic             d4_valid, d4_overflow;
  logic [EW-1:0]    d4_data;

  fiapp_fault_observer #(.CNT_W(CNT_W), .TS_W(TS_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .a(a), .enable(enable),
    .o1(o1), .o2(o2), .o3(o3), .clear(clear),
    .fault_flags(fault_flags), .fault_count(fault_count),
    .first_ts(first_ts), .first_type(first_type),
    .evt_valid(evt_valid), .evt_data(evt_data),
    .evt_ready(evt_ready), .evt_overflow(evt_overflow)
  );

  fiapp_fault_observer #(.CNT_W(4), .TS_W(TS_W), .DEPTH(DEPTH)) dut4 (
    .clk(clk), .reset_n(reset_n), .a(a), .enable(enable),
    .o1(o1), .o2(o2), .o3(o3), .clear(clear),
    .fault_flags(d4_flags), .fault_count(d4_count),
    .first_ts(d4_first_ts), .first_type(d4_first_type),
    .evt_valid(d4_valid), .evt_data(d4_data),
    .evt_ready(evt_ready), .evt_overflow(d4_overflow)
  );

  int errors = 0;
  int checks = 0;

  // correct fiapp: q1 loads a when enabled, q2 follows q1, o3 = ~q2
  bit f_q1, f_q2;
  bit frc_o1;   // force o1 high
  bit frc_o3;   // force o3 equal to o2

  // observer model
  int            m_ts;
  bit            m_shadow, m_prev, m_warm, m_latched, m_ovf;
  bit [2:0]      m_flags, m_first_type;
  int            m_count, m_count4, m_first_ts;
  logic [EW-1:0] m_q[$];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic compare_all();
    chk("flags", 64'(fault_flags), 64'(m_flags));
    chk("count", 64'(fault_count), 64'(m_count));
    chk("first_ts", 64'(first_ts), 64'(m_first_ts));
    chk("first_type", 64'(first_type), 64'(m_first_type));
    chk("evt_valid", 64'(evt_valid), 64'(m_q.size() > 0));
    chk("evt_overflow", 64'(evt_overflow), 64'(m_ovf));
    chk("d4_count", 64'(d4_count), 64'(m_count4));
    chk("d4_flags", 64'(d4_flags), 64'(m_flags));
    if (m_q.size() > 0) begin
      chk("evt_data", 64'(evt_data), 64'(m_q[0]));
    end
  endtask

  // One clock: drive observed outputs, advance the models, then compare after the edge.
  task automatic step();
    bit [2:0] t;
    bit       pop, full;
    o1 = frc_o1 ? 1'b1 : f_q1;
    o2 = f_q2;
    o3 = frc_o3 ? o2 : ~f_q2;
    if (!reset_n) begin
      m_ts = 0; m_shadow = 0; m_prev = 0; m_warm = 1; m_latched = 0; m_ovf = 0;
      m_flags = 0; m_first_type = 0; m_count = 0; m_count4 = 0; m_first_ts = 0;
      m_q.delete();
      f_q1 = 0; f_q2 = 0;
    end else begin
      t = 3'b000;
      if (!m_warm) begin
        t[2] = (o1 != m_shadow);
        t[1] = (o2 != m_prev);
        t[0] = (o3 == o2);
      end
      full = (m_q.size() == DEPTH);
      pop  = (m_q.size() > 0) && evt_ready;
      if (pop) void'(m_q.pop_front());
      if (t != 3'b000) begin
        if (full && !pop) m_ovf = 1;
        else m_q.push_back({m_ts[TS_W-1:0], t});
      end
      if (clear) begin
        m_flags = 0; m_count = 0; m_count4 = 0; m_first_ts = 0; m_first_type = 0;
        m_latched = 0;
      end else if (t != 3'b000) begin
        m_flags = m_flags | t;
        if (m_count < (1 << CNT_W) - 1) m_count++;
        if (m_count4 < 15) m_count4++;
        if (!m_latched) begin
          m_first_ts = m_ts; m_first_type = t; m_latched = 1;
        end
      end
      m_warm = 0;
      if (enable) m_shadow = a;
      m_prev = o1;
      m_ts = (m_ts + 1) % (1 << TS_W);
      f_q2 = f_q1;
      if (enable) f_q1 = a;
    end
    @(posedge clk);
    #1;
    compare_all();
  endtask

  initial begin
    reset_n = 0; a = 0; enable = 0; clear = 0; evt_ready = 0;
    frc_o1 = 0; frc_o3 = 0; f_q1 = 0; f_q2 = 0;

    // reset for two cycles
    step(); step();
    chk("rst_flags", 64'(fault_flags), 64'h0);
    chk("rst_count", 64'(fault_count), 64'h0);
    chk("rst_valid", 64'(evt_valid), 64'h0);
    reset_n = 1;

    // clean random run through a correct fiapp
    for (int i = 0; i < 50; i++) begin
      a = 1'($urandom); enable = 1'($urandom); evt_ready = 1'($urandom);
      step();
    end
    chk("clean_flags", 64'(fault_flags), 64'h0);
    chk("clean_valid", 64'(evt_valid), 64'h0);

    // golden fault at ts=10 with shadow_q1=0
    reset_n = 0; a = 0; enable = 0; evt_ready = 0;
    step();
    reset_n = 1;
    for (int i = 0; i < 10; i++) step();
    frc_o1 = 1;
    step();
    frc_o1 = 0;
    chk("gold_flags", 64'(fault_flags), 64'h4);
    chk("gold_count", 64'(fault_count), 64'h1);
    chk("gold_first_ts", 64'(first_ts), 64'd10);
    chk("gold_first_type", 64'(first_type), 64'h4);
    step();
    chk("shift_flags", 64'(fault_flags), 64'h6);
    chk("shift_count", 64'(fault_count), 64'h2);
    chk("shift_first_ts", 64'(first_ts), 64'd10);
    chk("shift_head", 64'(evt_data), {37'h0, 24'd10, 3'b100});
    evt_ready = 1;
    step(); step(); step();
    chk("drain_valid", 64'(evt_valid), 64'h0);

    // complement faults queued, then drained in order
    evt_ready = 0; frc_o3 = 1;
    step(); step(); step();
    frc_o3 = 0;
    chk("comp_flag0", 64'(fault_flags[0]), 64'h1);
    evt_ready = 1;
    for (int i = 0; i < 4; i++) step();

    // persistent fault overflows the FIFO
    clear = 1; step(); clear = 0;
    evt_ready = 0; frc_o3 = 1;
    for (int i = 0; i < DEPTH + 2; i++) step();
    frc_o3 = 0;
    chk("ovf_flag", 64'(evt_overflow), 64'h1);
    chk("ovf_count", 64'(fault_count), 64'(DEPTH + 2));
    evt_ready = 1;
    for (int i = 0; i < DEPTH + 2; i++) step();

    // saturation on the CNT_W=4 instance, then clear
    clear = 1; step(); clear = 0;
    frc_o3 = 1;
    for (int i = 0; i < 20; i++) step();
    frc_o3 = 0;
    chk("sat_count4", 64'(d4_count), 64'd15);
    chk("sat_count16", 64'(fault_count), 64'd20);
    clear = 1; step(); clear = 0;
    chk("clr_flags", 64'(fault_flags), 64'h0);
    chk("clr_count", 64'(fault_count), 64'h0);
    chk("clr_ovf_kept", 64'(evt_overflow), 64'h1);
    step(); step();

    // fault and clear in the same cycle
    evt_ready = 0; clear = 1; frc_o3 = 1;
    step();
    clear = 0; frc_o3 = 0;
    chk("fc_count", 64'(fault_count), 64'h0);
    chk("fc_first_type", 64'(first_type), 64'h0);
    chk("fc_valid", 64'(evt_valid), 64'h1);
    chk("fc_type", 64'(evt_data[2:0]), 64'h1);
    frc_o3 = 1; step(); frc_o3 = 0;
    for (int i = 0; i < 3; i++) begin
      a = 1'($urandom); enable = 1'($urandom);
      step();
    end

    // reset mid-stream with events pending
    reset_n = 0;
    step();
    chk("mrst_flags", 64'(fault_flags), 64'h0);
    chk("mrst_count", 64'(fault_count), 64'h0);
    chk("mrst_valid", 64'(evt_valid), 64'h0);
    chk("mrst_ovf", 64'(evt_overflow), 64'h0);
    chk("mrst_first_ts", 64'(first_ts), 64'h0);
    reset_n = 1;
    step(); step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fiapp_fault_observer.md
Name: fiapp_fault_observer

Overview:
- Sits directly downstream of the fault-injection app (the three-flop enable/shift block).
- Taps that block's stimulus inputs (a, enable) and its outputs (o1, o2, o3), and checks them each cycle against a golden shadow model.
- Detects corruption caused by DPI-driven fault injection, then counts, timestamps and queues each fault event for a consumer behind a valid/ready handshake.

Parameters:
- CNT_W, 16, width of saturating fault counter.
- TS_W, 24, width of free-running cycle timestamp.
- DEPTH, 8, event FIFO entries (power of 2, >=2).

Ports:
- clk  in  1  single clock.
- reset_n  in  1  synchronous, active-low reset.
- a  in  1  same stimulus data the observed block receives.
- enable  in  1  same load enable the observed block receives.
- o1  in  1  observed output o1.
- o2  in  1  observed output o2.
- o3  in  1  observed output o3.
- clear  in  1  pulse: clears sticky flags, count, first-fault snapshot.
- fault_flags  out  3  sticky: [0] complement, [1] shift, [2] golden.
- fault_count  out  CNT_W  saturating number of fault cycles.
- first_ts  out  TS_W  timestamp of first fault since reset/clear.
- first_type  out  3  check vector of first fault.
- evt_valid  out  1  event FIFO not empty.
- evt_data  out  TS_W+3  {ts, type} at FIFO head.
- evt_ready  in  1  consumer accepts head when evt_valid & evt_ready.
- evt_overflow  out  1  sticky: an event was dropped because FIFO was full.

Behaviour:
- Reset (clk edge with reset_n=0): all outputs 0; timestamp=0; shadow_q1=0; prev_o1=0; FIFO empty; state=WARMUP.
- Timestamp: increments every cycle out of reset; wraps modulo 2^TS_W.
- Shadow model: shadow_q1 <= enable ? a : shadow_q1 (mirrors the observed q1). prev_o1 <= o1 every cycle.
- Checks per cycle (only in MONITOR/LATCHED), forming type vector t:
  - t[0] complement: o3 != ~o2.
  - t[1] shift: o2 != prev_o1.
  - t[2] golden: o1 != shadow_q1.
- Fault cycle means t != 0. Multiple bits in one cycle give one event with all bits set.
- FSM:
  - WARMUP: one cycle, then MONITOR. Checks disabled because history is invalid.
  - MONITOR: on fault cycle, capture first_ts/first_type and go to LATCHED.
  - LATCHED: keep checking, counting and logging; first_* frozen. clear returns to MONITOR.
  - clear in MONITOR stays in MONITOR.
- On a fault cycle, at the next edge:
  - fault_flags |= t.
  - fault_count += 1, saturating at all-ones.
  - Push {ts, t} into the FIFO.
- clear has priority over a same-cycle fault: the fault is not counted and not latched, but is still pushed to the FIFO. FIFO contents and evt_overflow are never cleared by clear; only reset clears them.
- FIFO:
  - evt_data is registered head data, valid whenever evt_valid=1.
  - Pop on evt_valid & evt_ready.
  - Full with push and no pop: drop the new event and set evt_overflow.
  - Full with simultaneous push and pop: both succeed, no overflow.
  - Empty: evt_ready is ignored.
  - Pointers wrap at DEPTH.
- Latency: fault visible on fault_flags/fault_count/evt_valid 1 cycle after the offending cycle.
- reset_n low mid-operation: everything returns to reset values on that edge; in-flight events are lost.

Optional Feature:
- FIAPP_FAULT_OBSERVER_DPI_EN defined:
  - Module exports DPI-C function ObsGetFaultCount(output int cnt), returning fault_count zero-extended.
  - Module exports DPI-C function ObsGetFlags(output int flags), returning fault_flags zero-extended.
  - C-side fault-injection tests can poll the observer.
- Undefined: no DPI declarations. RTL behaviour is identical either way.

Test Plan:
- Clean run: reset_n low 2 cycles; 50 random cycles of a/enable fed through a correct fiapp model -> fault_flags=0, fault_count=0, evt_valid=0, state reaches MONITOR at cycle 1.
- Force o1=1 for one cycle at ts=10 while shadow_q1=0 -> cycle 11:
  - fault_flags=3'b100, fault_count=1, first_ts=10, first_type=3'b100.
  - Next cycle reports shift fault 3'b010 (ts=11); count=2; first_* unchanged.
- Force o3=o2 for 3 cycles with evt_ready=0 -> 3 events {ts, 3'b001}; fault_flags[0]=1. Then evt_ready=1 drains them in order with correct ts.
- Persistent fault for DEPTH+2 cycles with evt_ready=0 -> FIFO holds DEPTH entries; evt_overflow=1; fault_count=DEPTH+2.
- With CNT_W=4, 20 fault cycles -> fault_count saturates at 15. Then clear pulse -> flags=0, count=0, state MONITOR, FIFO untouched.
- Fault and clear in same cycle -> count stays 0 and first_* not latched, but one FIFO event is pushed. reset_n low mid-stream -> all outputs 0 next edge.
